// File: rtl/zion_rf_rd_pkg.sv
// zion_rf_rd_pkg: shared widths, types and helpers for the regfile read-port arbiter
package zion_rf_rd_pkg;
    localparam int RS_W     = 5;
    localparam int XLEN_MAX = 64;
    typedef logic [RS_W-1:0]     rs_t;
    typedef logic [XLEN_MAX-1:0] word_max_t;
    function automatic int xlen(input int rv64);
        return 32 * (1 + rv64);
    endfunction
endpackage

// File: rtl/zion_rr_arbiter.sv
// zion_rr_arbiter: combinational round-robin grant with a registered rotating pointer
module zion_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);
    logic [IW-1:0] ptr;
    int j;
    // first requester at or after ptr, wrapping modulo N
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!vld && req[j]) begin
                vld    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
    // pointer moves just past the winner; holds when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (vld)
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/zion_rf_rd_port_arbiter.sv
// zion_rf_rd_port_arbiter: shares one regfile read port among M requesters (optional ZION_RF_RD_ARB_X0_BYPASS_EN)
module zion_rf_rd_port_arbiter
    import zion_rf_rd_pkg::*;
#(
    parameter int RV64 = 0,
    parameter int M    = 4,
    localparam int XLEN = xlen(RV64),
    localparam int IW   = (M > 1) ? $clog2(M) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [M-1:0]        req_vld,
    input  logic [RS_W*M-1:0]   req_rs,
    output logic [M-1:0]        req_rdy,
    output logic [M-1:0]        rsp_vld,
    output logic [XLEN*M-1:0]   rsp_dat,
    input  logic [M-1:0]        rsp_rdy,
    output logic [RS_W-1:0]     rf_rs,
    input  logic [XLEN-1:0]     rf_dat
);
    typedef logic [XLEN-1:0] word_t;
    logic [M-1:0]  elig, byp, arb_req, gnt;
    logic [IW-1:0] idx;
    logic          vld;
    word_t         dat_q [M];
    // a slot may take a new read only if it is empty or drains this cycle
    always_comb begin
        elig = req_vld & (~rsp_vld | rsp_rdy) & {M{~flush & ~rst}};
        byp  = '0;
`ifdef ZION_RF_RD_ARB_X0_BYPASS_EN
        for (int i = 0; i < M; i++)
            byp[i] = elig[i] && (req_rs[RS_W*i +: RS_W] == '0);
`endif
        arb_req = elig & ~byp;
    end
    zion_rr_arbiter #(.N(M)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (gnt),
        .idx (idx),
        .vld (vld)
    );
    // drive the winner's index to the regfile; x0 bypasses never touch the port
    always_comb begin
        req_rdy = gnt | byp;
        rf_rs   = vld ? req_rs[RS_W*int'(idx) +: RS_W] : '0;
    end
    // response slots: a new load beats a same-cycle drain; flush empties all slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld <= '0;
            dat_q   <= '{default: '0};
        end else begin
            for (int i = 0; i < M; i++) begin
                if (gnt[i] || byp[i]) begin
                    rsp_vld[i] <= 1'b1;
                    dat_q[i]   <= gnt[i] ? rf_dat : '0;
                end else if (flush || rsp_rdy[i]) begin
                    rsp_vld[i] <= 1'b0;
                end
            end
        end
    end
    for (genvar g = 0; g < M; g++) begin : g_dat
        assign rsp_dat[XLEN*g +: XLEN] = dat_q[g];
    end
endmodule

// File: tb/tb_zion_rf_rd_port_arbiter.sv
// tb_zion_rf_rd_port_arbiter: directed vectors for the regfile read-port arbiter (RV64=1, M=4)
module tb_zion_rf_rd_port_arbiter;
    localparam int M = 4;
    localparam int XLEN = 64;
    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [M-1:0]      req_vld;
    logic [5*M-1:0]    req_rs;
    logic [M-1:0]      req_rdy;
    logic [M-1:0]      rsp_vld;
    logic [XLEN*M-1:0] rsp_dat;
    logic [M-1:0]      rsp_rdy;
    logic [4:0]        rf_rs;
    logic [XLEN-1:0]   rf_dat;
    int n_vec = 0;
    int n_bad = 0;

    zion_rf_rd_port_arbiter #(.RV64(1), .M(M)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .req_vld (req_vld),
        .req_rs  (req_rs),
        .req_rdy (req_rdy),
        .rsp_vld (rsp_vld),
        .rsp_dat (rsp_dat),
        .rsp_rdy (rsp_rdy),
        .rf_rs   (rf_rs),
        .rf_dat  (rf_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] slot(input int i);
        return rsp_dat[XLEN*i +: XLEN];
    endfunction

    logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [4:0] rr_rs  [5] = '{5'd7, 5'd1, 5'd2, 5'd3, 5'd7};
    int         rr_idx [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; flush = 1'b0; req_vld = 4'hF; rsp_rdy = 4'h0;
        req_rs = {5'd3, 5'd2, 5'd1, 5'd7}; rf_dat = '0;
        #2;
        chk("rst_rdy", req_rdy, 4'h0);
        chk("rst_rs", rf_rs, 5'd0);
        chk("rst_vld", rsp_vld, 4'h0);
        chk("rst_dat0", slot(0), 64'h0);
        cyc();
        rst = 1'b0; rsp_rdy = 4'hF;
        for (int k = 0; k < 5; k++) begin
            rf_dat = 64'hA000_0000_0000_0000 | 64'(k);
            #1;
            chk($sformatf("rr_gnt%0d", k), req_rdy, rr_gnt[k]);
            chk($sformatf("rr_rs%0d", k), rf_rs, rr_rs[k]);
            cyc();
            chk($sformatf("rr_dat%0d", k), slot(rr_idx[k]), 64'hA000_0000_0000_0000 | 64'(k));
        end
        req_vld = 4'h0; rsp_rdy = 4'hF;
        cyc();
        chk("idle_vld", rsp_vld, 4'h0);
        req_vld = 4'b0001; rf_dat = 64'hDEAD_BEEF; #1;
        chk("bp_gnt0", req_rdy, 4'b0001);
        cyc();
        req_vld = 4'b0011; rsp_rdy = 4'b1110; rf_dat = 64'h1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_rdy%0d", k), req_rdy, 4'b0010);
            cyc();
            chk($sformatf("bp_vld0_%0d", k), rsp_vld[0], 1'b1);
            chk($sformatf("bp_dat0_%0d", k), slot(0), 64'hDEAD_BEEF);
        end
        req_vld = 4'b0001; rsp_rdy = 4'b0001; rf_dat = 64'hCAFE_F00D; #1;
        chk("bp_regnt", req_rdy, 4'b0001);
        cyc();
        chk("bp_vld", rsp_vld, 4'b0011);
        chk("bp_newdat", slot(0), 64'hCAFE_F00D);
        req_vld = 4'hF; rsp_rdy = 4'h0; flush = 1'b1; rf_dat = 64'h2222; #1;
        chk("fl_rdy", req_rdy, 4'h0);
        chk("fl_rs", rf_rs, 5'd0);
        cyc();
        flush = 1'b0; #1;
        chk("fl_vld", rsp_vld, 4'h0);
        chk("fl_hold", slot(0), 64'hCAFE_F00D);
        chk("fl_ptr_gnt", req_rdy, 4'b0010);
        chk("fl_ptr_rs", rf_rs, 5'd1);
        cyc();
        req_vld = 4'b0100; rsp_rdy = 4'hF; req_rs[10 +: 5] = 5'd31;
        rf_dat = 64'h0123_4567_89AB_CDEF; #1;
        chk("w64_rs", rf_rs, 5'd31);
        chk("w64_gnt", req_rdy, 4'b0100);
        cyc();
        chk("w64_dat", slot(2), 64'h0123_4567_89AB_CDEF);
        req_vld = 4'h0;
        cyc();
        req_rs[0 +: 5] = 5'd0; req_rs[5 +: 5] = 5'd5; req_vld = 4'b0011;
`ifdef ZION_RF_RD_ARB_X0_BYPASS_EN
        rf_dat = 64'h55; #1;
        chk("x0_rdy", req_rdy, 4'b0011);
        chk("x0_rs", rf_rs, 5'd5);
        cyc();
        chk("x0_dat0", slot(0), 64'h0);
        chk("x0_dat1", slot(1), 64'h55);
        chk("x0_vld", rsp_vld, 4'b0011);
`else
        rf_dat = 64'hABC; #1;
        chk("x0_rdy_a", req_rdy, 4'b0001);
        chk("x0_rs_a", rf_rs, 5'd0);
        cyc();
        chk("x0_dat0", slot(0), 64'hABC);
        req_vld = 4'b0010; rf_dat = 64'h55; #1;
        chk("x0_rdy_b", req_rdy, 4'b0010);
        chk("x0_rs_b", rf_rs, 5'd5);
        cyc();
        chk("x0_dat1", slot(1), 64'h55);
`endif
        req_vld = 4'h0; rsp_rdy = 4'hF;
        cyc();
        req_rs = {5'd3, 5'd2, 5'd1, 5'd7}; req_vld = 4'b0101; rsp_rdy = 4'h0;
        cyc();
        cyc();
        chk("mr_vld", rsp_vld, 4'b0101);
        req_vld = 4'hF; rst = 1'b1; #1;
        chk("mr_rst_vld", rsp_vld, 4'h0);
        chk("mr_rst_rdy", req_rdy, 4'h0);
        chk("mr_rst_rs", rf_rs, 5'd0);
        cyc();
        rst = 1'b0; rsp_rdy = 4'hF; #1;
        chk("mr_first_gnt", req_rdy, 4'b0001);
        chk("mr_first_rs", rf_rs, 5'd7);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
